// File: rtl/tfhe_pu_sched_pkg.sv
// Shared types and constants for the TFHE PU job scheduler.
package tfhe_pu_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StError
  } sched_state_e;

  localparam int unsigned DescOpW   = 2;
  localparam int unsigned DescAddrW = 32;

  localparam logic [DescOpW-1:0] OP_PBS    = 2'd0;
  localparam logic [DescOpW-1:0] OP_KS     = 2'd1;
  localparam logic [DescOpW-1:0] OP_PBS_KS = 2'd2;
  localparam logic [DescOpW-1:0] OP_RSVD   = 2'd3;

  typedef struct packed {
    logic [DescOpW-1:0]   op;
    logic [DescAddrW-1:0] addr;
  } job_desc_t;

  localparam int unsigned LedBusy     = 0;
  localparam int unsigned LedFifoFull = 1;
  localparam int unsigned LedTimeout  = 2;
  localparam int unsigned LedDoneLsb  = 3;
  localparam int unsigned LedDoneW    = 5;

endpackage

// File: rtl/tfhe_pu_job_fifo.sv
// Synchronous job-descriptor FIFO with occupancy count and full/empty flags.
module tfhe_pu_job_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 34
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/tfhe_pu_job_scheduler.sv
// Host-to-PU job scheduler: queues descriptors, issues them one at a time,
// watches for completion or a hung PU, and publishes status/LEDs.
module tfhe_pu_job_scheduler
  import tfhe_pu_sched_pkg::*;
#(
  parameter int unsigned ADDR_W         = DescAddrW,
  parameter int unsigned OP_W           = DescOpW,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 32'd1 << 20
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   host_cmd_valid,
  output logic                   host_cmd_ready,
  input  logic [OP_W-1:0]        host_cmd_op,
  input  logic [ADDR_W-1:0]      host_cmd_addr,
  output logic                   pu_start,
  output logic [OP_W-1:0]        pu_op,
  output logic [ADDR_W-1:0]      pu_addr,
  input  logic                   pu_done,
  input  logic                   err_clear,
  output logic                   irq_done,
  output logic                   status_busy,
  output logic                   status_timeout,
  output logic [$clog2(DEPTH):0] status_fifo_level,
  output logic [15:0]            status_done_cnt,
  output logic [7:0]             leds
);

  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES - 1);

  sched_state_e      state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              timeout_q, timeout_d;
  logic [OP_W-1:0]   pu_op_q, pu_op_d;
  logic [ADDR_W-1:0] pu_addr_q, pu_addr_d;
  logic [15:0]       done_cnt_q;
  logic              irq_q;
  logic              rdy_q;
  logic              done_evt;

  job_desc_t push_desc, head_desc;
  logic      fifo_push, fifo_pop, fifo_full, fifo_empty;

  // Ready stays low while in reset and rises on the first edge after release.
  assign host_cmd_ready = rdy_q && !fifo_full;
  assign fifo_push      = host_cmd_valid && host_cmd_ready && (host_cmd_op != OP_RSVD);

  always_comb begin
    push_desc      = '0;
    push_desc.op   = host_cmd_op;
    push_desc.addr = host_cmd_addr;
  end

  tfhe_pu_job_fifo #(
    .Depth (DEPTH),
    .Width ($bits(job_desc_t))
  ) u_job_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (fifo_push),
    .wdata_i (push_desc),
    .pop_i   (fifo_pop),
    .rdata_o (head_desc),
    .count_o (status_fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The head is popped on the IDLE->ISSUE edge so pu_op/pu_addr are already
  // valid during the ISSUE cycle that drives pu_start.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    timeout_d = timeout_q;
    fifo_pop  = 1'b0;
    done_evt  = 1'b0;
    pu_op_d   = pu_op_q;
    pu_addr_d = pu_addr_q;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d   = StIssue;
          fifo_pop  = 1'b1;
          pu_op_d   = head_desc.op;
          pu_addr_d = head_desc.addr;
        end
      end
      StIssue: begin
        state_d = StWaitDone;
        timer_d = '0;
      end
      StWaitDone: begin
        if (pu_done) begin
          state_d  = StIdle;
          done_evt = 1'b1;
        end else if (timer_q == TimerMax) begin
          state_d   = StError;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StError: begin
        if (err_clear) begin
          state_d   = StIdle;
          timeout_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      timeout_q  <= 1'b0;
      pu_op_q    <= '0;
      pu_addr_q  <= '0;
      done_cnt_q <= '0;
      irq_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      pu_op_q   <= pu_op_d;
      pu_addr_q <= pu_addr_d;
      irq_q     <= done_evt;
      rdy_q     <= 1'b1;
      if (done_evt) begin
        done_cnt_q <= done_cnt_q + 16'd1;
      end
    end
  end

  assign pu_start        = (state_q == StIssue);
  assign pu_op           = pu_op_q;
  assign pu_addr         = pu_addr_q;
  assign irq_done        = irq_q;
  assign status_busy     = (state_q == StIssue) || (state_q == StWaitDone);
  assign status_timeout  = timeout_q;
  assign status_done_cnt = done_cnt_q;

  always_comb begin
    leds                            = '0;
    leds[LedBusy]                   = status_busy;
    leds[LedFifoFull]               = fifo_full;
    leds[LedTimeout]                = timeout_q;
    leds[LedDoneLsb +: LedDoneW]    = done_cnt_q[LedDoneW-1:0];
  end

endmodule

// File: tb/tb_tfhe_pu_job_scheduler.sv
// Self-checking bench: directed scenarios plus randomized jobs against a queue model.
module tb_tfhe_pu_job_scheduler;

  localparam int unsigned Depth   = 4;
  localparam int unsigned Timeout = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        host_cmd_valid = 1'b0;
  logic        host_cmd_ready;
  logic [1:0]  host_cmd_op = 2'd0;
  logic [31:0] host_cmd_addr = 32'd0;
  logic        pu_start;
  logic [1:0]  pu_op;
  logic [31:0] pu_addr;
  logic        pu_done = 1'b0;
  logic        err_clear = 1'b0;
  logic        irq_done;
  logic        status_busy;
  logic        status_timeout;
  logic [2:0]  status_fifo_level;
  logic [15:0] status_done_cnt;
  logic [7:0]  leds;

  tfhe_pu_job_scheduler #(
    .ADDR_W         (32),
    .OP_W           (2),
    .DEPTH          (Depth),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .host_cmd_valid    (host_cmd_valid),
    .host_cmd_ready    (host_cmd_ready),
    .host_cmd_op       (host_cmd_op),
    .host_cmd_addr     (host_cmd_addr),
    .pu_start          (pu_start),
    .pu_op             (pu_op),
    .pu_addr           (pu_addr),
    .pu_done           (pu_done),
    .err_clear         (err_clear),
    .irq_done          (irq_done),
    .status_busy       (status_busy),
    .status_timeout    (status_timeout),
    .status_fifo_level (status_fifo_level),
    .status_done_cnt   (status_done_cnt),
    .leds              (leds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
  } job_t;

  job_t        model_q[$];
  int          checks = 0;
  int          errors = 0;
  int          start_cnt = 0;
  logic [15:0] exp_done = 16'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every issued job must be the oldest non-reserved descriptor still queued.
  always @(posedge clk) begin
    #1;
    if (pu_start === 1'b1) begin
      start_cnt++;
      if (model_q.size() == 0) begin
        chk("unexpected_start", {63'd0, pu_start}, 64'd0);
      end else begin
        job_t j;
        j = model_q.pop_front();
        chk("pu_op", {62'd0, pu_op}, {62'd0, j.op});
        chk("pu_addr", {32'd0, pu_addr}, {32'd0, j.addr});
      end
    end
  end

  task automatic push(input logic [1:0] op, input logic [31:0] addr);
    bit done_push;
    done_push      = 1'b0;
    host_cmd_valid = 1'b1;
    host_cmd_op    = op;
    host_cmd_addr  = addr;
    for (int i = 0; i < 40 && !done_push; i++) begin
      if (host_cmd_ready === 1'b1) begin
        tick();
        if (op != 2'd3) model_q.push_back('{op, addr});
        done_push = 1'b1;
      end else begin
        tick();
      end
    end
    host_cmd_valid = 1'b0;
    if (!done_push) chk("push_timeout", {63'd0, host_cmd_ready}, 64'd1);
  endtask

  task automatic wait_start();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (pu_start === 1'b1) seen = 1'b1;
      else tick();
    end
    if (!seen) chk("start_timeout", {63'd0, pu_start}, 64'd1);
  endtask

  // Pulse pu_done n cycles after the current one; caller ensures WAIT_DONE.
  task automatic done_after(input int n);
    repeat (n) tick();
    pu_done = 1'b1;
    tick();
    pu_done = 1'b0;
    exp_done++;
    chk("irq_done", {63'd0, irq_done}, 64'd1);
    chk("done_cnt", {48'd0, status_done_cnt}, {48'd0, exp_done});
    chk("led_done", {59'd0, leds[7:3]}, {59'd0, exp_done[4:0]});
    chk("busy_after_done", {63'd0, status_busy}, 64'd0);
    tick();
    chk("irq_pulse", {63'd0, irq_done}, 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, {63'd0, host_cmd_ready}, 64'd0);
    chk({tag, "_start"}, {63'd0, pu_start}, 64'd0);
    chk({tag, "_pu_op"}, {62'd0, pu_op}, 64'd0);
    chk({tag, "_pu_addr"}, {32'd0, pu_addr}, 64'd0);
    chk({tag, "_irq"}, {63'd0, irq_done}, 64'd0);
    chk({tag, "_busy"}, {63'd0, status_busy}, 64'd0);
    chk({tag, "_timeout"}, {63'd0, status_timeout}, 64'd0);
    chk({tag, "_level"}, {61'd0, status_fifo_level}, 64'd0);
    chk({tag, "_cnt"}, {48'd0, status_done_cnt}, 64'd0);
    chk({tag, "_leds"}, {56'd0, leds}, 64'd0);
  endtask

  initial begin
    int saved;
    logic [1:0]  rop;
    logic [31:0] raddr;

    // Reset
    #1 reset_n = 1'b0;
    #2 check_all_zero("rst");
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("ready_after_rst", {63'd0, host_cmd_ready}, 64'd1);

    // Single job: latency 2, done 5 cycles after start
    push(2'd0, 32'h1000);
    chk("no_early_start", {63'd0, pu_start}, 64'd0);
    tick();
    chk("start_lat2", {63'd0, pu_start}, 64'd1);
    chk("addr_lat2", {32'd0, pu_addr}, 64'h1000);
    chk("busy_issue", {63'd0, status_busy}, 64'd1);
    done_after(5);
    chk("led3", {63'd0, leds[3]}, 64'd1);

    // Reserved op dropped; stray pu_done in IDLE ignored
    saved = start_cnt;
    push(2'd3, 32'hDEAD);
    chk("rsvd_level", {61'd0, status_fifo_level}, 64'd0);
    repeat (4) tick();
    chk("rsvd_no_start", 64'(start_cnt), 64'(saved));
    pu_done = 1'b1;
    tick();
    pu_done = 1'b0;
    tick();
    chk("stray_irq", {63'd0, irq_done}, 64'd0);
    chk("stray_cnt", {48'd0, status_done_cnt}, {48'd0, exp_done});

    // Fill the FIFO with the PU stalled
    push(2'd1, 32'hA000);
    wait_start();
    for (int i = 0; i < 4; i++) push(2'($urandom_range(0, 2)), $urandom);
    chk("full_level", {61'd0, status_fifo_level}, 64'd4);
    chk("full_ready", {63'd0, host_cmd_ready}, 64'd0);
    chk("full_led", {63'd0, leds[1]}, 64'd1);
    host_cmd_valid = 1'b1;
    host_cmd_op    = 2'd2;
    host_cmd_addr  = 32'hF5F5;
    repeat (2) tick();
    chk("full_hold", {61'd0, status_fifo_level}, 64'd4);
    pu_done = 1'b1;
    tick();
    pu_done = 1'b0;
    exp_done++;
    chk("full_irq", {63'd0, irq_done}, 64'd1);
    chk("full_no_push", {61'd0, status_fifo_level}, 64'd4);
    push(2'd2, 32'hF5F5);
    done_after(1);
    for (int i = 0; i < 4; i++) begin
      wait_start();
      done_after($urandom_range(1, 8));
    end
    chk("drain_model", 64'(model_q.size()), 64'd0);

    // Watchdog timeout, late done ignored, push in ERROR, err_clear resumes
    push(2'd0, 32'h6000);
    push(2'd1, 32'h7000);
    wait_start();
    repeat (Timeout) tick();
    chk("pre_timeout", {63'd0, status_timeout}, 64'd0);
    chk("pre_timeout_busy", {63'd0, status_busy}, 64'd1);
    tick();
    chk("timeout_flag", {63'd0, status_timeout}, 64'd1);
    chk("timeout_led", {63'd0, leds[2]}, 64'd1);
    chk("err_busy", {63'd0, status_busy}, 64'd0);
    saved = start_cnt;
    pu_done = 1'b1;
    tick();
    pu_done = 1'b0;
    tick();
    chk("late_irq", {63'd0, irq_done}, 64'd0);
    chk("late_cnt", {48'd0, status_done_cnt}, {48'd0, exp_done});
    chk("err_level1", {61'd0, status_fifo_level}, 64'd1);
    push(2'd2, 32'h8000);
    chk("err_level2", {61'd0, status_fifo_level}, 64'd2);
    repeat (3) tick();
    chk("err_no_start", 64'(start_cnt), 64'(saved));
    chk("err_sticky", {63'd0, status_timeout}, 64'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("err_cleared", {63'd0, status_timeout}, 64'd0);
    wait_start();
    done_after(2);
    wait_start();
    done_after(1);

    // Done on the same cycle as the timeout limit: done wins
    push(2'd1, 32'h9000);
    wait_start();
    done_after(Timeout);
    chk("race_no_timeout", {63'd0, status_timeout}, 64'd0);

    // Randomized jobs
    for (int i = 0; i < 12; i++) begin
      rop   = 2'($urandom_range(0, 3));
      raddr = $urandom;
      push(rop, raddr);
      if (rop != 2'd3) begin
        wait_start();
        done_after($urandom_range(1, Timeout - 1));
      end else begin
        repeat (3) tick();
        chk("rand_rsvd_level", {61'd0, status_fifo_level}, 64'd0);
      end
    end
    chk("rand_model", 64'(model_q.size()), 64'd0);

    // Reset mid-job with two queued
    push(2'd0, 32'hB000);
    push(2'd1, 32'hC000);
    push(2'd2, 32'hD000);
    chk("mid_level", {61'd0, status_fifo_level}, 64'd2);
    chk("mid_busy", {63'd0, status_busy}, 64'd1);
    reset_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_q.delete();
    exp_done = 16'd0;
    saved = start_cnt;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    chk("post_rst_level", {61'd0, status_fifo_level}, 64'd0);
    chk("post_rst_ready", {63'd0, host_cmd_ready}, 64'd1);
    repeat (10) tick();
    chk("post_rst_no_start", 64'(start_cnt), 64'(saved));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
